// File: rtl/regfile_pkg.sv
// Shared defaults and the clear-sweep state encoding for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear-sweep sequencer: walks indices 1..NREG-1, one per cycle, then returns to IDLE.
module rf_clear_seq
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req_i,
   output logic              clr_busy_o,
   output logic [ADDR_W-1:0] clr_idx_o
);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              busy_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req_i) begin
                  state_q <= ST_CLEAR;
                  idx_q   <= ADDR_W'(1);
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               // Last index swept: leave via IDLE so idx never overflows.
               if (idx_q == '1) begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy_o = busy_q;
   assign clr_idx_o  = idx_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with R0 hardwired to zero, a busy scoreboard,
// write-to-read bypass and a sequenced clear sweep.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ok,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;

   logic              sweep;
   logic [ADDR_W-1:0] sweep_idx;
   logic              wb;
   logic              rsv_set;

   rf_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear (
      .clk        (clk),
      .rst        (rst),
      .clr_req_i  (clr_req),
      .clr_busy_o (sweep),
      .clr_idx_o  (sweep_idx)
   );

   assign clr_busy = sweep;

   // Writebacks to R0 are dropped here so R0 storage and busy never change.
   assign wb      = wr_en & ~sweep & (wr_addr != '0);
   assign rsv_ok  = rsv_en & ~sweep &
                    ((rsv_addr == '0) | ~busy_q[rsv_addr] | (wb & (wr_addr == rsv_addr)));
   assign rsv_set = rsv_ok & (rsv_addr != '0);

   always_comb begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
      if (rd_addr1 != '0) begin
         if (wb && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
         end else begin
            rd_data1 = regs_q[rd_addr1];
            rd_busy1 = busy_q[rd_addr1];
         end
      end
   end

   always_comb begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
      if (rd_addr2 != '0) begin
         if (wb && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
         end else begin
            rd_data2 = regs_q[rd_addr2];
            rd_busy2 = busy_q[rd_addr2];
         end
      end
   end

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (sweep) begin
         regs_d[sweep_idx] = '0;
         busy_d[sweep_idx] = 1'b0;
      end else begin
         if (wb) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
         end
         // A same-cycle reservation wins over the writeback's busy clear.
         if (rsv_set) begin
            busy_d[rsv_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [3:0]  rd_addr1, rd_addr2;
   logic [15:0] rd_data1, rd_data2;
   logic        rd_busy1, rd_busy2;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic        rsv_ok;
   logic        clr_req;
   logic        clr_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt;

   regfile_sb #(
      .DATA_W (16),
      .ADDR_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .rd_busy1 (rd_busy1),
      .rd_busy2 (rd_busy2),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rsv_ok   (rsv_ok),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
      tick(); tick();
      rst = 1'b1;
      rd_addr1 = 4'd3; rd_addr2 = 4'd7;
      settle();
      check("rst_data1", rd_data1, 0);
      check("rst_data2", rd_data2, 0);
      check("rst_busy1", rd_busy1, 0);
      check("rst_rsv_ok", rsv_ok, 0);
      check("rst_clr_busy", clr_busy, 0);

      // Write then read next cycle
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0; rd_addr1 = 4'd3;
      settle();
      check("r3_read", rd_data1, 16'hBEEF);

      // Same-cycle bypass
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; rd_addr2 = 4'd5;
      settle();
      check("r5_bypass", rd_data2, 16'h1234);
      tick();
      wr_en = 1'b0;
      settle();
      check("r5_stored", rd_data2, 16'h1234);

      // R0 hardwired
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr1 = 4'd0;
      settle();
      check("r0_no_bypass", rd_data1, 0);
      tick();
      wr_en = 1'b0;
      settle();
      check("r0_read", rd_data1, 0);
      rsv_en = 1'b1; rsv_addr = 4'd0;
      settle();
      check("r0_rsv_ok", rsv_ok, 1);
      tick();
      rsv_en = 1'b0;
      settle();
      check("r0_busy", rd_busy1, 0);

      // Reserve R7, refused retry, writeback clears busy
      rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr1 = 4'd7;
      settle();
      check("r7_rsv_ok", rsv_ok, 1);
      tick();
      settle();
      check("r7_busy", rd_busy1, 1);
      check("r7_rsv_refused", rsv_ok, 0);
      tick();
      rsv_en = 1'b0;
      settle();
      check("r7_busy_kept", rd_busy1, 1);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
      settle();
      check("r7_wb_busy", rd_busy1, 0);
      check("r7_wb_data", rd_data1, 16'h00AA);
      tick();
      wr_en = 1'b0;
      settle();
      check("r7_busy_after", rd_busy1, 0);
      check("r7_data_after", rd_data1, 16'h00AA);

      // Reserve R9, then same-cycle writeback + reserve R9
      rsv_en = 1'b1; rsv_addr = 4'd9; rd_addr2 = 4'd9;
      tick();
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A;
      settle();
      check("r9_rsv_with_wb", rsv_ok, 1);
      tick();
      wr_en = 1'b0; rsv_en = 1'b0;
      settle();
      check("r9_busy", rd_busy2, 1);
      check("r9_data", rd_data2, 16'h5A5A);

      // Fill R1..R15, reserve R4, then sweep
      for (int i = 1; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(16'h1111 * i);
         tick();
      end
      wr_en = 1'b0;
      rsv_en = 1'b1; rsv_addr = 4'd4;
      tick();
      rsv_en = 1'b0; rd_addr1 = 4'd4; rd_addr2 = 4'd15;
      settle();
      check("fill_r4_busy", rd_busy1, 1);
      check("fill_r15", rd_data2, 16'hFFFF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h0BAD;
      rsv_en = 1'b1; rsv_addr = 4'd2;
      rd_addr1 = 4'd4;
      settle();
      check("clr_start", clr_busy, 1);
      check("clr_rsv_ok", rsv_ok, 0);
      check("clr_no_bypass", rd_data2, 16'hFFFF);
      check("clr_r4_busy", rd_busy1, 1);
      check("clr_r4_data", rd_data1, 16'h4444);
      cnt = 0;
      while (clr_busy && cnt < 40) begin
         cnt++;
         tick();
         settle();
      end
      check("clr_cycles", cnt, 15);
      wr_en = 1'b0; rsv_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_addr1 = 4'(i);
         settle();
         check("post_clr_data", rd_data1, 0);
         check("post_clr_busy", rd_busy1, 0);
      end

      // Reset in the middle of a sweep
      wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'hCCCC;
      tick();
      wr_addr = 4'd2; wr_data = 16'h2222;
      rsv_en = 1'b1; rsv_addr = 4'd13;
      tick();
      wr_en = 1'b0; rsv_en = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      settle();
      check("mid_clr_busy", clr_busy, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      rd_addr1 = 4'd12; rd_addr2 = 4'd13;
      settle();
      check("rst_mid_clr_busy", clr_busy, 0);
      check("rst_mid_r12", rd_data1, 0);
      check("rst_mid_r13_busy", rd_busy2, 0);
      rd_addr2 = 4'd2;
      settle();
      check("rst_mid_r2", rd_data2, 0);
      wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h0123;
      tick();
      wr_en = 1'b0;
      settle();
      check("rst_mid_idle_wr", rd_data1, 16'h0123);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, 4, register index width; NREG = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read port source indices.
REQ-006 SHALL have ports rd_data1, rd_data2  output  DATA_W  combinational read data.
REQ-007 SHALL have ports rd_busy1, rd_busy2  output  1  source has an outstanding reservation.
REQ-008 SHALL have ports wr_en  input  1,  wr_addr  input  ADDR_W,  wr_data  input  DATA_W  writeback port.
REQ-009 SHALL have ports rsv_en  input  1,  rsv_addr  input  ADDR_W  destination reservation at issue.
REQ-010 SHALL have port rsv_ok  output  1  reservation accepted this cycle.
REQ-011 SHALL have ports clr_req  input  1  start clear sweep;  clr_busy  output  1  sweep in progress.

Function
REQ-012 SHALL hold register 0 at constant zero: reads return 0, writes ignored, busy[0] always 0, rsv_ok always 1 for rsv_addr 0.
REQ-013 SHALL return rd_dataN = wr_data when wr_en=1, wr_addr=rd_addrN, rd_addrN!=0, state IDLE (write bypass); else the stored value.
REQ-014 SHALL drive rd_busyN = busy[rd_addrN] except 0 when the same-cycle writeback targets rd_addrN.
REQ-015 SHALL store wr_data into wr_addr on the edge when wr_en=1 and state IDLE, whether or not the register is busy.
REQ-016 SHALL clear busy[wr_addr] on a writeback, unless a same-cycle accepted reservation targets the same index (busy ends 1).
REQ-017 SHALL drive rsv_ok = rsv_en & IDLE & (!busy[rsv_addr] | writeback to rsv_addr this cycle); an accepted reservation sets busy[rsv_addr] next edge.
REQ-018 SHALL leave state unchanged on a refused reservation; requester retries.
REQ-019 SHALL implement FSM IDLE/CLEAR: IDLE + clr_req -> CLEAR, index counter loaded with 1.
REQ-020 SHALL in CLEAR write 0 to register[idx] and clear busy[idx] each cycle, idx incrementing; after idx=NREG-1 return to IDLE (NREG-1 CLEAR cycles).
REQ-021 SHALL drive clr_busy=1 exactly while in CLEAR; clr_req, wr_en, rsv_en ignored in CLEAR; rsv_ok=0 in CLEAR.
REQ-022 SHALL serve reads during CLEAR from stored contents without bypass (already-swept indices read 0).
REQ-023 SHALL wrap idx counter only via the return to IDLE; no overflow past NREG-1.

Reset
REQ-024 SHALL on rst=0 at an edge zero all registers, all busy bits, idx, and enter IDLE, overriding any in-flight CLEAR, write or reservation.
REQ-025 SHALL after reset present rd_data*=0, rd_busy*=0, rsv_ok=0 (rsv_en=0), clr_busy=0.

Structure
REQ-026 SHALL take the IDLE/CLEAR state enum and DATA_W/ADDR_W defaults from shared package regfile_pkg.
REQ-027 SHALL place the clear FSM and idx counter in one sub-module rf_clear_seq; storage, scoreboard and bypass stay in regfile_sb.

Verification
REQ-028 SHALL cover: write R3=0xBEEF, next cycle read port1 R3 -> 0xBEEF; same-cycle write+read R5=0x1234 -> 0x1234 via bypass.
REQ-029 SHALL cover: write R0=0xFFFF, read R0 -> 0x0000; rsv_en on R0 -> rsv_ok=1, rd_busy for R0 stays 0.
REQ-030 SHALL cover: reserve R7 -> rsv_ok=1, rd_busy=1 next cycle; reserve R7 again -> rsv_ok=0; writeback R7=0x00AA -> rd_busy 0 same cycle, data 0x00AA.
REQ-031 SHALL cover: same cycle writeback R9 and reserve R9 -> rsv_ok=1, busy[9]=1 afterward, R9 holds written data.
REQ-032 SHALL cover: fill R1..R15 with 0x1111*i, reserve R4, clr_req -> clr_busy high exactly 15 cycles, wr_en ignored, then all reads 0 and busy all 0.
REQ-033 SHALL cover: rst=0 mid-CLEAR at idx=6 -> next cycle IDLE, clr_busy=0, all registers 0.
